// File: rtl/ttl_counter_chain.sv
// Cascaded 4-bit synchronous counter chain ('161/'163 style) with a toggle
// stage and a one-clock pulse on every terminal-count event.
module ttl_counter_chain #(
  parameter int STAGES   = 2,
  parameter int CLR_SYNC = 1,
  parameter int AUTOLOAD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  clr_n,
  input  logic                  load_n,
  input  logic                  ent,
  input  logic                  enp,
  input  logic [4*STAGES-1:0]   d,
  output logic [4*STAGES-1:0]   q,
  output logic                  rco,
  output logic                  tff_q,
  output logic                  tc_pulse
);

  localparam int W        = 4 * STAGES;
  localparam bit AUTO_EN  = (AUTOLOAD != 0);
  localparam bit SYNC_CLR = (CLR_SYNC != 0);

  logic [W-1:0]      count_q, count_d;
  logic              tff_state_q, tff_state_d;
  logic              tc_pulse_q, tc_pulse_d;
  logic [STAGES:0]   carry;
  logic [W-1:0]      inc_val;
  logic              ld;
  logic              tce;

  // Each nibble steps when every lower nibble is all-ones, like RCO->ENT wiring.
  assign carry[0] = ent;
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      assign carry[gi+1]          = carry[gi] & (&count_q[4*gi +: 4]);
      assign inc_val[4*gi +: 4]   = carry[gi] ? count_q[4*gi +: 4] + 4'd1
                                              : count_q[4*gi +: 4];
    end
  endgenerate

  assign rco = carry[STAGES];
  assign ld  = ~load_n | (AUTO_EN & rco);
  assign tce = clk_en & rco & enp & clr_n;

  always_comb begin
    count_d     = count_q;
    tff_state_d = tff_state_q;
    tc_pulse_d  = 1'b0;
    if (!SYNC_CLR && !clr_n) begin
      count_d = '0;
    end else if (clk_en) begin
      if (!clr_n) begin
        count_d = '0;
      end else if (ld) begin
        count_d = d;
      end else if (enp) begin
        count_d = inc_val;
      end
      if (tce) begin
        tff_state_d = ~tff_state_q;
        tc_pulse_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      tff_state_q <= 1'b0;
      tc_pulse_q  <= 1'b0;
    end else begin
      count_q     <= count_d;
      tff_state_q <= tff_state_d;
      tc_pulse_q  <= tc_pulse_d;
    end
  end

  assign q        = count_q;
  assign tff_q    = tff_state_q;
  assign tc_pulse = tc_pulse_q;

endmodule

// File: tb/tb_ttl_counter_chain.sv
// Bench for ttl_counter_chain: three parameter variants share one stimulus
// stream and are checked against a cycle-level reference model.
module tb_ttl_counter_chain;

  logic       clk = 1'b0;
  logic       reset, clk_en, clr_n, load_n, ent, enp;
  logic [7:0] d;

  logic [7:0] q_a, q_b, q_c;
  logic       rco_a, rco_b, rco_c;
  logic       tff_a, tff_b, tff_c;
  logic       tc_a, tc_b, tc_c;

  always #5 clk = ~clk;

  // a: '163 clear, no autoload; b: '163 clear, autoload; c: '161 clear
  ttl_counter_chain #(.STAGES(2), .CLR_SYNC(1), .AUTOLOAD(0)) u_a (
    .clk(clk), .reset(reset), .clk_en(clk_en), .clr_n(clr_n), .load_n(load_n),
    .ent(ent), .enp(enp), .d(d), .q(q_a), .rco(rco_a), .tff_q(tff_a), .tc_pulse(tc_a));
  ttl_counter_chain #(.STAGES(2), .CLR_SYNC(1), .AUTOLOAD(1)) u_b (
    .clk(clk), .reset(reset), .clk_en(clk_en), .clr_n(clr_n), .load_n(load_n),
    .ent(ent), .enp(enp), .d(d), .q(q_b), .rco(rco_b), .tff_q(tff_b), .tc_pulse(tc_b));
  ttl_counter_chain #(.STAGES(2), .CLR_SYNC(0), .AUTOLOAD(0)) u_c (
    .clk(clk), .reset(reset), .clk_en(clk_en), .clr_n(clr_n), .load_n(load_n),
    .ent(ent), .enp(enp), .d(d), .q(q_c), .rco(rco_c), .tff_q(tff_c), .tc_pulse(tc_c));

  logic [7:0] dq   [3];
  logic       drco [3];
  logic       dtff [3];
  logic       dtc  [3];
  assign dq[0] = q_a;     assign dq[1] = q_b;     assign dq[2] = q_c;
  assign drco[0] = rco_a; assign drco[1] = rco_b; assign drco[2] = rco_c;
  assign dtff[0] = tff_a; assign dtff[1] = tff_b; assign dtff[2] = tff_c;
  assign dtc[0] = tc_a;   assign dtc[1] = tc_b;   assign dtc[2] = tc_c;

  bit cfg_sync [3] = '{1'b1, 1'b1, 1'b0};
  bit cfg_auto [3] = '{1'b0, 1'b1, 1'b0};

  logic [7:0] mq   [3];
  logic       mtff [3];
  logic       mtc  [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Advance one clk edge, updating the reference model from the rules.
  task automatic tick();
    logic [7:0] nq [3];
    logic       nt [3];
    logic       nc [3];
    for (int k = 0; k < 3; k++) begin
      logic at_tc;
      at_tc = ent && (mq[k] == 8'hFF);
      nq[k] = mq[k];
      nt[k] = mtff[k];
      nc[k] = 1'b0;
      if (reset) begin
        nq[k] = 8'h00;
        nt[k] = 1'b0;
      end else if (!cfg_sync[k] && !clr_n) begin
        nq[k] = 8'h00;
      end else if (clk_en) begin
        if (!clr_n)                          nq[k] = 8'h00;
        else if (!load_n || (cfg_auto[k] && at_tc)) nq[k] = d;
        else if (ent && enp)                 nq[k] = mq[k] + 8'd1;
        if (at_tc && enp && clr_n) begin
          nt[k] = !mtff[k];
          nc[k] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      mq[k] = nq[k]; mtff[k] = nt[k]; mtc[k] = nc[k];
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; clk_en = 1'b1; ent = 1'b1; enp = 1'b1;
    clr_n = 1'b1; load_n = 1'b1; d = 8'h00;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dq[k] !== 8'h00 || dtff[k] !== 1'b0 || dtc[k] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: q=%h tff=%b tc=%b required q=00 tff=0 tc=0", k, dq[k], dtff[k], dtc[k]);
      end
    end
    reset = 1'b0;
    tick();
    n_checks++;
    if (q_a !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_first_count: q=%h required 01", q_a);
    end
    $display("reset: q_a=%h tff_a=%b tc_a=%b", q_a, tff_a, tc_a);
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q  [3] = '{8'hFF, 8'h00, 8'h01};
    logic       exp_rc [3] = '{1'b1, 1'b0, 1'b0};
    logic       exp_tc [3] = '{1'b0, 1'b1, 1'b0};
    clk_en = 1'b1; load_n = 1'b0; d = 8'hFE; tick();
    load_n = 1'b1;
    for (int s = 0; s < 3; s++) begin
      tick();
      n_checks++;
      if (q_a !== exp_q[s] || rco_a !== exp_rc[s] || tc_a !== exp_tc[s]) begin
        n_fail++;
        $display("FAIL wrap step %0d: q=%h rco=%b tc=%b required q=%h rco=%b tc=%b",
                 s, q_a, rco_a, tc_a, exp_q[s], exp_rc[s], exp_tc[s]);
      end
      $display("wrap step %0d: q_a=%h rco_a=%b tc_a=%b tff_a=%b", s, q_a, rco_a, tc_a, tff_a);
    end
    n_checks++;
    if (tff_a !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_tff: tff=%b required 1", tff_a);
    end
  endtask

  task automatic test_autoload();
    int   pulses = 0;
    int   last   = 0;
    logic tff0;
    clr_n = 1'b1; ent = 1'b1; enp = 1'b1; d = 8'hFA;
    clk_en = 1'b1; load_n = 1'b0; tick();
    load_n = 1'b1;
    tff0 = mtff[1];
    for (int s = 1; s <= 30; s++) begin
      logic [7:0] exp;
      clk_en = 1'b1;
      tick();
      exp = 8'hFA + 8'(s % 6);
      n_checks++;
      if (q_b !== exp) begin
        n_fail++;
        $display("FAIL autoload_q strobe %0d: q=%h required %h", s, q_b, exp);
      end
      if (tc_b === 1'b1) begin
        pulses++;
        if (last != 0) begin
          n_checks++;
          if (s - last != 6) begin
            n_fail++;
            $display("FAIL autoload_spacing: %0d strobes required 6", s - last);
          end
        end
        last = s;
      end
      $display("autoload strobe %0d: q_b=%h tc_b=%b tff_b=%b", s, q_b, tc_b, tff_b);
      if ($urandom_range(0, 1) == 1) begin
        clk_en = 1'b0;
        tick();
        n_checks++;
        if (tc_b !== 1'b0 || q_b !== exp) begin
          n_fail++;
          $display("FAIL autoload_gap: q=%h tc=%b required q=%h tc=0", q_b, tc_b, exp);
        end
      end
    end
    n_checks++;
    if (pulses != 5 || tff_b !== ~tff0) begin
      n_fail++;
      $display("FAIL autoload_count: pulses=%0d tff=%b required pulses=5 tff=%b", pulses, tff_b, ~tff0);
    end
  endtask

  task automatic test_clear_priority();
    logic tff0;
    clr_n = 1'b1; ent = 1'b1; enp = 1'b1; clk_en = 1'b1;
    load_n = 1'b0; d = 8'hFF; tick();
    clr_n = 1'b0; load_n = 1'b0; d = 8'h42;
    #1;
    n_checks++;
    if (rco_a !== 1'b1) begin
      n_fail++;
      $display("FAIL clrpri_rco: rco=%b required 1", rco_a);
    end
    tff0 = mtff[0];
    tick();
    n_checks++;
    if (q_a !== 8'h00 || tc_a !== 1'b0 || tff_a !== tff0) begin
      n_fail++;
      $display("FAIL clrpri: q=%h tc=%b tff=%b required q=00 tc=0 tff=%b", q_a, tc_a, tff_a, tff0);
    end
    clr_n = 1'b1; load_n = 1'b0; d = 8'h5A; tick();
    clk_en = 1'b0; clr_n = 1'b0; load_n = 1'b1; tick();
    n_checks++;
    if (q_a !== 8'h5A) begin
      n_fail++;
      $display("FAIL clr_no_strobe: q=%h required 5A", q_a);
    end
    $display("clear priority: q_a=%h tc_a=%b tff_a=%b", q_a, tc_a, tff_a);
    clr_n = 1'b1;
  endtask

  task automatic test_async_clear();
    clr_n = 1'b1; clk_en = 1'b1; load_n = 1'b0; d = 8'h37; tick();
    load_n = 1'b1; clk_en = 1'b0; clr_n = 1'b0; tick();
    n_checks++;
    if (q_c !== 8'h00 || q_a !== 8'h37) begin
      n_fail++;
      $display("FAIL clr161: q_c=%h q_a=%h required q_c=00 q_a=37", q_c, q_a);
    end
    $display("161 clear: q_c=%h q_a=%h", q_c, q_a);
    clr_n = 1'b1;
  endtask

  task automatic test_enables();
    clk_en = 1'b1; ent = 1'b1; enp = 1'b1; load_n = 1'b0; d = 8'hFF; tick();
    load_n = 1'b1; enp = 1'b0;
    for (int s = 0; s < 4; s++) begin
      tick();
      n_checks++;
      if (q_a !== 8'hFF || rco_a !== 1'b1 || tc_a !== 1'b0 || tc_b !== 1'b0) begin
        n_fail++;
        $display("FAIL enp_hold %0d: q=%h rco=%b tc_a=%b tc_b=%b required FF 1 0 0",
                 s, q_a, rco_a, tc_a, tc_b);
      end
    end
    ent = 1'b0;
    #1;
    n_checks++;
    if (rco_a !== 1'b0 || rco_b !== 1'b0) begin
      n_fail++;
      $display("FAIL ent_rco: rco_a=%b rco_b=%b required 0", rco_a, rco_b);
    end
    $display("enables: q_a=%h rco_a=%b after ent=0", q_a, rco_a);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(0, 39) == 0);
      clk_en = ($urandom_range(0, 2) != 0);
      clr_n  = ($urandom_range(0, 11) != 0);
      load_n = ($urandom_range(0, 9) != 0);
      ent    = ($urandom_range(0, 7) != 0);
      enp    = ($urandom_range(0, 5) != 0);
      d      = ($urandom_range(0, 3) == 0) ? 8'hFF : (8'hF0 | 8'($urandom_range(0, 15)));
      tick();
      for (int k = 0; k < 3; k++) begin
        logic exp_rco;
        exp_rco = ent && (mq[k] == 8'hFF);
        n_checks++;
        if (dq[k] !== mq[k] || dtff[k] !== mtff[k] || dtc[k] !== mtc[k] || drco[k] !== exp_rco) begin
          n_fail++;
          $display("FAIL random %0d inst %0d: q=%h tff=%b tc=%b rco=%b required q=%h tff=%b tc=%b rco=%b",
                   i, k, dq[k], dtff[k], dtc[k], drco[k], mq[k], mtff[k], mtc[k], exp_rco);
        end
      end
      $display("random %0d: rst=%b en=%b clr_n=%b ld_n=%b ent=%b enp=%b d=%h | q=%h/%h/%h tc=%b%b%b",
               i, reset, clk_en, clr_n, load_n, ent, enp, d, q_a, q_b, q_c, tc_a, tc_b, tc_c);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_autoload();
    test_clear_priority();
    test_async_clear();
    test_enables();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ttl_counter_chain.md
# ttl_counter_chain

Parametrised chain of 74x161/74x163-style 4-bit synchronous counters with a 74x109-style toggle stage on the terminal count. It replaces hand-wired counter and flip-flop clusters in the sound and timing sections with one block. It advances only on a count strobe (e.g. `clk_6KHz_en`), so one system clock serves all instances. Typical uses: programmable frequency dividers (reload-on-carry), noise/tone period counters and square-wave generators.

## Interface
Parameters:
- `STAGES`, default 2: number of cascaded 4-bit stages; counter width `W = 4*STAGES`; legal range 1..8.
- `CLR_SYNC`, default 1: selects the clear style.
  - 1: '163-style; clear acts only on `clk_en` cycles.
  - 0: '161-style; clear acts on every `clk` edge regardless of `clk_en`.
- `AUTOLOAD`, default 0: selects the load source.
  - 1: `rco` acts as an internal load request, giving a divide-by-(2^W − d) divider.
  - 0: load comes only from `load_n`.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high. Overrides every other input.
- `clk_en` in 1: count strobe emulating the TTL clock edge. Single-cycle pulses or held high are both legal.
- `clr_n` in 1: active-low clear.
- `load_n` in 1: active-low parallel load.
- `ent` in 1: count enable T; also gates `rco`.
- `enp` in 1: count enable P.
- `d` in W: parallel load data.
- `q` out W: counter value.
- `rco` out 1: ripple carry out, combinational.
- `tff_q` out 1: toggle flip-flop output, a divide-by-2 of terminal-count events.
- `tc_pulse` out 1: one-`clk` registered pulse per terminal-count event.

## Operation
- **Reset** (`reset`=1 at an edge): `q`=0, `tff_q`=0, `tc_pulse`=0. Reset overrides everything else.
- **Load request:** `ld = !load_n | (AUTOLOAD & rco)`.
- **Clear when `CLR_SYNC`=0:** on any `clk` edge with `clr_n`=0, `q`←0. `clk_en` is ignored and `tff_q` is unaffected. `tc_pulse`←0 on that edge.
- **Update on a `clk_en`=1 edge** (not in reset), first matching rule wins:
  1. `clr_n`=0 (CLR_SYNC=1): `q`←0.
  2. `ld`: `q`←`d`.
  3. `ent & enp`: `q`←`q`+1 modulo 2^W. Full-width increment, equivalent to cascading each stage's RCO into the next stage's ENT. Wraps from all-ones to 0.
  4. Otherwise: `q` holds.
- **Carry:** `rco = ent & (q == {W{1'b1}})`. It is independent of `enp`, `clr_n` and `clk_en`.
- **Terminal-count event (`tce`):** a `clk_en` edge with `rco`=1, `enp`=1, `clr_n`=1, not in reset. It counts whether the next value comes from wrap, external load or autoload.
  - On `tce`: `tff_q`←!`tff_q` and `tc_pulse`←1.
  - On every other edge: `tc_pulse`←0 and `tff_q` holds.
- **`clk_en`=0:** `q`, `tff_q` hold (except '161-style clear and reset); `tc_pulse`←0.
- **Simultaneous `clr_n`=0 and `ld`:** clear wins; no `tce`.
- **Autoload:** with AUTOLOAD=1 and `d` = all-ones, the counter reloads all-ones every enabled strobe. `rco` stays 1, so `tce` fires every `clk_en` with `enp`=1. This behaviour is required and is not an error.
- **`ent`=0:** no counting, `rco`=0, so no autoload and no `tce`. External load still works.

## Timing
- `q`, `tff_q` and `tc_pulse` update on the `clk` edge that samples the qualifying `clk_en`: one `clk` of latency and no further pipeline.
- `rco` follows `q`/`ent` combinationally in the same cycle. It must not be registered.
- `tc_pulse` is high for exactly one `clk` even when `clk_en` is held high and `tce` repeats. Consecutive `tce` cycles give consecutive high cycles.
- AUTOLOAD divider period is (2^W − d) strobes for `d` ≠ all-ones, and 1 strobe for `d` = all-ones.
- The `tff_q` period is twice the `tce` period.
- Reset mid-count: outputs are 0 on the next edge and counting resumes on the first `clk_en` after `reset` falls.

## Test plan
- **Reset:** drive `reset`=1 for 2 clk with `clk_en`=1, `ent`=`enp`=1 → `q`=0, `tff_q`=0, `tc_pulse`=0. Release `reset`, then one strobe → `q`=1.
- **Wrap (STAGES=2):** load `d`=8'hFE, then 3 strobes with `ent`=`enp`=1 → `q` = FF, then 00, then 01. `rco`=1 only while `q`=FF. One `tc_pulse` on the FF→00 edge. `tff_q` goes 0→1.
- **Autoload divider (STAGES=2, AUTOLOAD=1, `d`=8'hFA), 30 strobes:** `q` cycles FA..FF, giving a period of 6 strobes. 5 `tc_pulse`s 6 strobes apart. `tff_q` has a 12-strobe period.
- **Clear priority (CLR_SYNC=1):** `clr_n`=0, `load_n`=0 and `rco`=1 on one strobe → `q`=0, no `tc_pulse`, `tff_q` unchanged. With `clk_en`=0, `clr_n`=0 → `q` holds.
- **'161-style clear (CLR_SYNC=0):** `q`=8'h37, `clk_en`=0, pulse `clr_n`=0 for one clk → `q`=0 on that edge.
- **Enables:** at `q`=FF, hold `enp`=0, `ent`=1 for 4 strobes → `q` holds FF, `rco`=1, no `tc_pulse`. Set `ent`=0 → `rco`=0 the same cycle.
